// File: rtl/serial_alu_if.sv
// Handshake and operand/result bundle for serial_alu.
// The producer side uses the master modport; serial_alu uses slave.
interface serial_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/serial_alu.sv
// Digit-serial ALU: one DIGIT-bit slice per clock, carry kept in a flop between digits.
// Optional SERIAL_ALU_EARLY_DONE_EN: logic ops and op 111 complete in one cycle.
module serial_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input logic          clk,
    input logic          rst,
    serial_alu_if.slave  bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpNor = 3'b101;
    localparam logic [2:0] OpSlt = 3'b110;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_alu: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic             accept, last, is_sub, is_arith, in_arith;
    logic [31:0]      base;
    logic [DIGIT-1:0] a_dig, b_dig, b_eff, dsum, dlogic;
    logic             dcarry, sum_msb, v_add, v_sub;
    logic [WIDTH-1:0] res_word, early_res;

    function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (f)
            OpAnd:   return x & y;
            OpOr:    return x | y;
            OpXor:   return x ^ y;
            OpNor:   return ~(x | y);
            default: return '0;
        endcase
    endfunction

    assign accept   = bus.in_valid && (state_q == StIdle);
    assign last     = (cnt_q == CW'(NDIG - 1));
    assign is_sub   = (op_q == OpSub) || (op_q == OpSlt);
    assign is_arith = (op_q == OpAdd) || is_sub;
    assign in_arith = (bus.op == OpAdd) || (bus.op == OpSub) || (bus.op == OpSlt);

    assign base    = 32'(cnt_q) * DIGIT;
    assign a_dig   = DIGIT'(a_q >> base);
    assign b_dig   = DIGIT'(b_q >> base);
    assign b_eff   = is_sub ? ~b_dig : b_dig;
    assign {dcarry, dsum} = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
    assign dlogic  = DIGIT'(logic_fn(op_q, WIDTH'(a_dig), WIDTH'(b_dig)));

    // Final-digit flags use the MSB of the last sum digit and the latched operand MSBs.
    assign sum_msb = dsum[DIGIT-1];
    assign v_add   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_msb != a_q[WIDTH-1]);
    assign v_sub   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_msb != a_q[WIDTH-1]);

    assign early_res = logic_fn(bus.op, bus.a, bus.b);

    always_comb begin
        res_word = res_q;
        res_word[base +: DIGIT] = is_arith ? dsum : dlogic;
        if (last && (op_q == OpSlt)) begin
            res_word = WIDTH'(sum_msb ^ v_sub);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef SERIAL_ALU_EARLY_DONE_EN
                    state_d = in_arith ? StRun : StDone;
`else
                    state_d = StRun;
`endif
                end
            end
            StRun:   if (last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.result    = res_q;
        bus.carry_out = cout_q;
        bus.overflow  = ovf_q;
        bus.zero      = zero_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    carry_d = (bus.op == OpSub) || (bus.op == OpSlt);
                    cnt_d   = '0;
`ifdef SERIAL_ALU_EARLY_DONE_EN
                    if (!in_arith) begin
                        res_d  = early_res;
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                        zero_d = (early_res == '0);
                    end
`endif
                end
            end
            StRun: begin
                res_d   = res_word;
                cnt_d   = cnt_q + CW'(1);
                carry_d = dcarry;
                if (last) begin
                    cout_d = ((op_q == OpAdd) || (op_q == OpSub)) ? dcarry : 1'b0;
                    ovf_d  = (op_q == OpAdd) ? v_add : (is_sub ? v_sub : 1'b0);
                    zero_d = (res_word == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_serial_alu.sv
// Randomized self-checking bench for serial_alu against a plain-arithmetic reference model.
// Honours SERIAL_ALU_EARLY_DONE_EN for the expected logic-op latency.
module tb_serial_alu;
    localparam int unsigned WIDTH = 32;
    parameter int unsigned  DIGIT = 4;
    localparam int unsigned NDIG  = WIDTH / DIGIT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_alu_if #(.WIDTH(WIDTH)) bus ();

    serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                  output logic c, output logic v, output logic z);
        longint sa, sb, hi, lo, s, d;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -(longint'(1) <<< (WIDTH - 1));
        s  = sa + sb;
        d  = sa - sb;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > {1'b0, {WIDTH{1'b1}}};
                        v = (s > hi) || (s < lo); end
            3'd1: begin r = a - b; c = (a >= b); v = (d > hi) || (d < lo); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a | b);
            3'd6: begin r = WIDTH'(sa < sb); v = (d > hi) || (d < lo); end
            default: r = '0;
        endcase
        z = (r == '0);
    endfunction

    function automatic int exp_latency(input logic [2:0] op);
`ifdef SERIAL_ALU_EARLY_DONE_EN
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd6)) return 1;
`endif
        return NDIG;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("accept_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a  = $urandom;
        bus.b  = $urandom;
        bus.op = 3'($urandom);
    endtask

    task automatic collect(input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input bit do_hs);
        logic [WIDTH-1:0] r;
        logic c, v, z;
        int lat = 0;
        model(op, a, b, r, c, v, z);
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < int'(NDIG) + 8);
        check_eq("latency", lat, exp_latency(op));
        check_eq("result", bus.result, r);
        check_eq("carry_out", bus.carry_out, c);
        check_eq("overflow", bus.overflow, v);
        check_eq("zero", bus.zero, z);
        check_eq("ready_low_in_done", bus.in_ready, 0);
        if (do_hs) begin
            @(posedge clk); #1;
            check_eq("valid_drop_after_hs", bus.out_valid, 0);
            check_eq("ready_after_hs", bus.in_ready, 1);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        send(op, a, b);
        collect(op, a, b, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] r;
        logic c, v, z;
        int pulses;
        int stop;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_carry", bus.carry_out, 0);
        check_eq("rst_overflow", bus.overflow, 0);
        check_eq("rst_zero", bus.zero, 0);

        // Directed cases
        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(3'd1, 32'd5, 32'd7);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op(3'd6, 32'h8000_0000, 32'h0000_0001);
        run_op(3'd6, 32'h0000_0001, 32'h8000_0000);
        run_op(3'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(3'd5, 32'h0000_0000, 32'h0000_0000);

        // Backpressure: new operands offered while DONE is stalled
        send(3'd0, 32'h0000_1111, 32'h0000_2222);
        collect(3'd0, 32'h0000_1111, 32'h0000_2222, 1'b0);
        model(3'd0, 32'h0000_1111, 32'h0000_2222, r, c, v, z);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 3'd1;
        bus.a = 32'h0000_0100;
        bus.b = 32'h0000_0001;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_in_ready", bus.in_ready, 0);
            check_eq("bp_result", bus.result, r);
            check_eq("bp_flags", {bus.carry_out, bus.overflow, bus.zero}, {c, v, z});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_hs_valid", bus.out_valid, 0);
        check_eq("bp_hs_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        collect(3'd1, 32'h0000_0100, 32'h0000_0001, 1'b1);

        // Reset in the middle of RUN
        send(3'd0, 32'hAAAA_AAAA, 32'h5555_5555);
        stop = (NDIG > 3) ? 3 : int'(NDIG) - 1;
        repeat (stop) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_in_ready", bus.in_ready, 1);
        pulses = 0;
        repeat (NDIG + 3) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        check_eq("midrst_no_pulse", pulses, 0);
        run_op(3'd0, 32'h1234_5678, 32'h1111_1111);
        check_eq("post_rst_add", bus.result, 32'h2345_6789);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [WIDTH-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 0) ? a : WIDTH'($urandom);
            run_op(op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Digit-serial, parametrised successor to the team's combinational ripple-carry adder datapath.
- Processes WIDTH-bit operands DIGIT bits per clock through one DIGIT-bit adder/logic slice.
- Carry is held in a flop between digits.
- Valid/ready handshakes on input and output, so it drops into the pipelined 32-bit ALU path in place of the full-width adder when area matters more than latency.

Parameters:
- WIDTH, 32: operand/result width in bits.
- DIGIT, 4: bits processed per cycle. WIDTH % DIGIT must be 0; elaboration error otherwise.
- NDIG, WIDTH/DIGIT: derived local parameter, the digit count N.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT (signed), 111 reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  result word.
- carry_out  output  1  carry from MSB (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB/SLT).
- zero  output  1  result == 0.

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1: state←IDLE, digit counter←0, carry flop←0, result/carry_out/overflow/zero←0, out_valid←0. After reset, in_ready=1.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, op; carry←1 for SUB/SLT, else 0; counter←0; go to RUN.
  - RUN: in_ready=0. Each cycle process digit k = counter, bits [k*DIGIT +: DIGIT].
    - Arithmetic: sum = a_k + (SUB/SLT ? ~b_k : b_k) + carry; write into result digit k; carry←digit carry-out.
    - Logic ops: bitwise per digit; carry unused.
    - When counter==NDIG-1, go to DONE after that digit, and compute flags from final carry and MSB operand/sum bits.
  - DONE: out_valid=1. Hold result and flags stable until out_valid&&out_ready, then go to IDLE.
- Latency: out_valid rises exactly NDIG cycles after the accepting edge. Minimum initiation interval is NDIG+2 cycles (DONE handshake cycle plus one IDLE cycle). in_ready is never high in the same cycle as out_valid.
- Flags:
  - ADD: carry_out = final carry; overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - SUB: computed as a+~b+1. carry_out = final carry (1 means no borrow); overflow = (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]).
  - SLT: result = {WIDTH-1 zeros, sum[MSB]^V}, where V is the SUB overflow; overflow reports V; carry_out=0.
  - Logic ops: carry_out=0, overflow=0.
  - op 111: result=0, carry_out=0, overflow=0, zero=1.
  - zero always reflects the final result word.
- Boundary conditions:
  - in_valid while not IDLE: ignored; no latch, no state change.
  - Operand inputs may change after acceptance without effect.
  - rst during RUN or DONE: operation abandoned; no out_valid pulse; in_ready=1 the cycle after reset deasserts.
  - DIGIT==WIDTH: NDIG=1; RUN lasts one cycle.
  - out_ready held high: DONE lasts exactly one cycle.

Optional Feature:
- Macro: SERIAL_ALU_EARLY_DONE_EN.
- Defined:
  - Logic ops (AND/OR/XOR/NOR) and op 111 bypass RUN. The full-width result is computed in IDLE on acceptance and the block enters DONE directly, so out_valid rises 1 cycle after the accepting edge.
  - Arithmetic ops are unchanged.
- Undefined: all ops take NDIG cycles as above.
- Port list is identical in both builds.

Test Plan:
- WIDTH=32, DIGIT=4. ADD a=0xFFFFFFFF, b=0x00000001, out_ready=1 -> out_valid exactly 8 cycles after accept; result=0x00000000, carry_out=1, overflow=0, zero=1.
- SUB a=5, b=7 -> result=0xFFFFFFFE, carry_out=0, overflow=0, zero=0. ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, carry_out=0.
- SLT a=0x80000000, b=0x00000001 -> result=1. SLT a=1, b=0x80000000 -> result=0. Both with overflow=1, matching the SUB V flag.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> result/flags stable; in_ready=0; new op not taken. out_ready=1 -> handshake; in_ready=1 next cycle; new op then accepted.
- rst=1 for one cycle at RUN digit 3 -> no out_valid pulse; in_ready=1 after reset. Next ADD 0x12345678+0x11111111 -> 0x23456789.
- DIGIT=32 build: ADD 0xFFFFFFFF+1 -> out_valid 1 cycle after accept. With SERIAL_ALU_EARLY_DONE_EN and WIDTH=32, DIGIT=4: XOR 0xF0F0F0F0^0xFFFFFFFF -> 0x0F0F0F0F, 1 cycle after accept.
